// File: rtl/panel_pkg.sv
// panel_pkg: shared geometry, pixel field offsets and scan FSM states
package panel_pkg;
    localparam int COLS       = 64;
    localparam int HALF_ROWS  = 32;
    localparam int COLOR_BITS = 8;
    localparam int R_OFS      = 16;
    localparam int G_OFS      = 8;
    localparam int B_OFS      = 0;
    typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_e;
endpackage

// File: rtl/panel_image_seq.sv
// panel_image_seq: image select sequencing, applied only at frame boundaries
module panel_image_seq
    import panel_pkg::*;
#(
    parameter int AUTO_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       next_img,
    input  logic       auto_en,
    output logic [1:0] image_sel
);
    localparam int AW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
    logic          pend_q, pend_d;
    logic [AW-1:0] auto_q, auto_d;
    logic [1:0]    img_q, img_d;
    logic          tc;
    assign tc = auto_en && auto_q == AW'(AUTO_FRAMES - 1);
    // Manual and automatic requests merge into a single +1 at frame end
    always_comb begin
        pend_d = frame_end ? 1'b0 : pend_q | next_img;
        auto_d = !auto_en ? '0 : frame_end ? (tc ? '0 : auto_q + 1'b1) : auto_q;
        img_d  = frame_end && (pend_q || next_img || tc) ? img_q + 2'd1 : img_q;
    end
    // Sequencing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            auto_q <= '0;
            img_q  <= '0;
        end else begin
            pend_q <= pend_d;
            auto_q <= auto_d;
            img_q  <= img_d;
        end
    end
    assign image_sel = img_q;
endmodule

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: HUB75 1/32-scan refresh with BCM and non-overlapped shift/display
module panel_scan_ctrl #(
    parameter int COLS        = panel_pkg::COLS,
    parameter int HALF_ROWS   = panel_pkg::HALF_ROWS,
    parameter int BASE_ON     = 1,
    parameter int AUTO_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_img,
    input  logic        auto_en,
    output logic [11:0] addr_top,
    output logic [11:0] addr_bottom,
    output logic [1:0]  image_sel,
    input  logic [23:0] pix_top,
    input  logic [23:0] pix_bottom,
    output logic        hub_r1,
    output logic        hub_g1,
    output logic        hub_b1,
    output logic        hub_r2,
    output logic        hub_g2,
    output logic        hub_b2,
    output logic [4:0]  hub_row,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic        frame_done
);
    import panel_pkg::*;
    localparam logic [15:0] SHIFT_LAST = 16'(2 * COLS + 1);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  row_q, row_d, hub_row_q, hub_row_d;
    logic [2:0]  plane_q, plane_d;
    logic        hclk_q, hclk_d;
    logic [5:0]  rgb_q, rgb_d;
    logic [23:0] pt, pb;
    logic        disp_last, frame_end;
    assign disp_last = state_q == DISPLAY && cnt_q == (16'(BASE_ON) << plane_q) - 16'd1;
    assign frame_end = disp_last && plane_q == 3'(COLOR_BITS - 1) && row_q == 5'(HALF_ROWS - 1);
    assign pt = pix_top >> plane_q;
    assign pb = pix_bottom >> plane_q;
    // Scan sequencing: shift, blank, latch, then display for the plane's BCM weight
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        row_d     = row_q;
        plane_d   = plane_q;
        hub_row_d = hub_row_q;
        case (state_q)
            SHIFT: if (cnt_q == SHIFT_LAST) begin
                state_d   = BLANK;
                cnt_d     = '0;
                hub_row_d = row_q;
            end
            BLANK: begin
                state_d = LATCH;
                cnt_d   = '0;
            end
            LATCH: begin
                state_d = DISPLAY;
                cnt_d   = '0;
            end
            default: if (disp_last) begin
                state_d = SHIFT;
                cnt_d   = '0;
                plane_d = plane_q + 3'd1;
                if (plane_q == 3'(COLOR_BITS - 1))
                    row_d = row_q == 5'(HALF_ROWS - 1) ? '0 : row_q + 5'd1;
            end
        endcase
    end
    // Shift pipeline: pins load on odd cycles from returned pixels, hub_clk pulses one cycle later
    always_comb begin
        hclk_d = state_q == SHIFT && !cnt_q[0] && cnt_q >= 16'd2;
        rgb_d  = state_q == SHIFT && cnt_q[0] && cnt_q < SHIFT_LAST
               ? {pt[R_OFS], pt[G_OFS], pt[B_OFS], pb[R_OFS], pb[G_OFS], pb[B_OFS]} : rgb_q;
    end
    // Controller state and registered HUB75 pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SHIFT;
            cnt_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            hub_row_q <= '0;
            hclk_q    <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            hub_row_q <= hub_row_d;
            hclk_q    <= hclk_d;
            rgb_q     <= rgb_d;
        end
    end
    panel_image_seq #(.AUTO_FRAMES(AUTO_FRAMES)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_end (frame_end),
        .next_img  (next_img),
        .auto_en   (auto_en),
        .image_sel (image_sel)
    );
    // Bottom-half marker bit follows rst_n so every address output reads zero in reset
    assign addr_top    = {1'b0, row_q, cnt_q[6:1]};
    assign addr_bottom = {rst_n, row_q, cnt_q[6:1]};
    assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = rgb_q;
    assign hub_row    = hub_row_q;
    assign hub_clk    = hclk_q;
    assign hub_lat    = state_q == LATCH;
    assign hub_oe_n   = state_q != DISPLAY;
    assign frame_done = frame_end;
endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl: cycle-accurate check of panel_scan_ctrl against a frame-timing reference model
module tb_panel_scan_ctrl;
    localparam int C  = 16;
    localparam int H  = 8;
    localparam int AF = 2;
    localparam int S  = 2 * C + 2;
    localparam int RL = 8 * (S + 2) + 255;
    localparam int F  = H * RL;

    logic        clk = 1'b0, rst_n = 1'b0, next_img = 1'b0, auto_en = 1'b0;
    logic [11:0] addr_top, addr_bottom;
    logic [1:0]  image_sel;
    logic [23:0] pix_top = '0, pix_bottom = '0;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic [4:0]  hub_row;
    logic        hub_clk, hub_lat, hub_oe_n, frame_done;
    logic [23:0] mem [0:16383];
    int          n_chk = 0, n_bad = 0;
    int          t = 0, m_img = 0, m_pend = 0, m_auto = 0;

    panel_scan_ctrl #(.COLS(C), .HALF_ROWS(H), .BASE_ON(1), .AUTO_FRAMES(AF)) dut (
        .clk(clk), .rst_n(rst_n), .next_img(next_img), .auto_en(auto_en),
        .addr_top(addr_top), .addr_bottom(addr_bottom), .image_sel(image_sel),
        .pix_top(pix_top), .pix_bottom(pix_bottom),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
        .hub_row(hub_row), .hub_clk(hub_clk), .hub_lat(hub_lat),
        .hub_oe_n(hub_oe_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pix_top    <= mem[{image_sel, addr_top}];
        pix_bottom <= mem[{image_sel, addr_bottom}];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_reset(input string sfx);
        check({"rst_oe_n", sfx}, 32'(hub_oe_n), 32'd1);
        check({"rst_lat", sfx}, 32'(hub_lat), 32'd0);
        check({"rst_hclk", sfx}, 32'(hub_clk), 32'd0);
        check({"rst_row", sfx}, 32'(hub_row), 32'd0);
        check({"rst_fd", sfx}, 32'(frame_done), 32'd0);
        check({"rst_img", sfx}, 32'(image_sel), 32'd0);
        check({"rst_atop", sfx}, 32'(addr_top), 32'd0);
        check({"rst_abot", sfx}, 32'(addr_bottom), 32'd0);
        check({"rst_pins", sfx}, 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'd0);
    endtask

    // Expected outputs derived from the position of cycle t within the frame schedule
    task automatic check_cycle();
        int tf, row, k, plane, col, prow;
        logic [23:0] et, eb;
        tf = t % F;
        row = tf / RL;
        k = tf % RL;
        plane = 0;
        while (plane < 7 && k >= S + 2 + (1 << plane)) begin
            k -= S + 2 + (1 << plane);
            plane++;
        end
        prow = (plane == 0 && k < S) ? (t < S ? 0 : (row + H - 1) % H) : row;
        check("oe_n", 32'(hub_oe_n), 32'(k < S + 2));
        check("lat", 32'(hub_lat), 32'(k == S + 1));
        check("hclk", 32'(hub_clk), 32'(k < S && k >= 3 && k % 2 == 1));
        check("hub_row", 32'(hub_row), 32'(prow));
        check("frame_done", 32'(frame_done), 32'(tf == F - 1));
        check("image_sel", 32'(image_sel), 32'(m_img));
        if (k < 2 * C && k % 2 == 0) begin
            check("addr_top", 32'(addr_top), 32'(row * 64 + k / 2));
            check("addr_bottom", 32'(addr_bottom), 32'(2048 + row * 64 + k / 2));
        end
        if (k >= 2 && k < S) begin
            col = (k - 2) / 2;
            et = mem[14'(m_img * 4096 + row * 64 + col)] >> plane;
            eb = mem[14'(m_img * 4096 + 2048 + row * 64 + col)] >> plane;
            check("pins", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}),
                  32'({et[16], et[8], et[0], eb[16], eb[8], eb[0]}));
        end
    endtask

    // Image sequencing rules, applied with the inputs seen at this clock edge
    task automatic model_step();
        logic fe, tc;
        fe = (t % F) == F - 1;
        if (!auto_en) m_auto = 0;
        tc = auto_en && m_auto == AF - 1;
        if (fe) begin
            if (m_pend != 0 || next_img || tc) m_img = (m_img + 1) % 4;
            m_pend = 0;
            if (auto_en) m_auto = tc ? 0 : m_auto + 1;
        end else if (next_img) begin
            m_pend = 1;
        end
        t++;
    endtask

    task automatic cycle(input logic ni);
        @(negedge clk);
        check_cycle();
        next_img = ni;
        @(posedge clk);
        model_step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        t = 0;
        m_img = 0;
        m_pend = 0;
        m_auto = 0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 24'($urandom);
        for (int c = 0; c < C; c++) mem[c] = (c % 2 == 0) ? 24'h010000 : 24'h000000;
        repeat (3) @(negedge clk);
        #1 check_reset("");
        release_reset();
        // Manual requests: three pulses in frame 0 give one advance at the boundary
        for (int i = 0; i < F + 50; i++) cycle(i == 1000 || i == 1500 || i == 2000);
        check("img_after_f0", 32'(image_sel), 32'd1);
        // Automatic advance with manual pulses, some on terminal-count frame ends
        auto_en = 1'b1;
        for (int i = 0; i < 8 * F; i++)
            cycle(((t % F) == F - 1 && (t / F) % 2 == 1) || $urandom_range(0, 2999) == 0);
        // auto_en toggling: counter held at zero whenever disabled
        for (int i = 0; i < F; i++) begin
            if (i % 700 == 0) auto_en = 1'(($urandom_range(0, 1)));
            cycle($urandom_range(0, 1999) == 0);
        end
        auto_en = 1'b0;
        // Asynchronous reset in the middle of row 5's first shift
        for (int i = 0; i < F && (t % F) != 5 * RL + 11; i++) cycle(1'b0);
        check("mid_reset_reached", 32'(t % F), 32'(5 * RL + 11));
        #2 rst_n = 1'b0;
        #1 check_reset("_mid");
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < 2 * RL; i++) cycle(1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
